piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage sitting directly upstream of the byte-assembling SIPO converter.
- Accepts bytes over a valid/ready handshake and emits them LSB-first as a bit stream qualified by out_valid; out_valid/serial_out wire straight to the SIPO's in_valid/serial_in.
- Inserts a mandatory idle gap after each byte: the SIPO spends one cycle presenting its word and ignores input during that cycle.

Parameters:
- DATA_WIDTH, 8, bits per word; must match the downstream SIPO width.
- GAP_CYCLES, 1, idle cycles (out_valid=0) forced after the last bit of each word; legal range 1..15.
- LSB_FIRST, 1, 1 = bit 0 transmitted first (SIPO fills bit 0 first); 0 = MSB first.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset; the block's only reset.
- data_in  input  DATA_WIDTH  parallel word to transmit.
- in_valid  input  1  data_in valid; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
- in_ready  output  1  holding register empty; equals !hold_full, registered, no combinational path from in_valid.
- serial_out  output  1  current serial bit; 0 whenever out_valid=0.
- out_valid  output  1  serial_out carries a data bit this cycle.
- busy  output  1  1 in SHIFT or GAP, or when the holding register is full.

Behaviour:
- Reset (async assert, sampled deassert): in_ready=1, serial_out=0, out_valid=0, busy=0. Holding register, shifter and counters are cleared, and the state is IDLE.
- Reset mid-word aborts the transfer immediately. No partial bits resume after release.
- Storage: one holding register (hold_data, hold_full) plus a DATA_WIDTH shift register. One word can be accepted while the previous word shifts.
- Accept: at an edge with in_valid & in_ready, hold_data <= data_in and hold_full <= 1. in_valid while in_ready=0 is ignored; the upstream must hold data until it is accepted.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If hold_full: load the shifter from hold_data, clear hold_full, set bit_cnt=0, go to SHIFT.
  - A word accepted at edge N is loaded at edge N+1. Its first bit is visible with out_valid=1 in the cycle after edge N+1 (2-cycle accept-to-first-bit latency).
- SHIFT:
  - out_valid=1.
  - serial_out = shifter[0] if LSB_FIRST, else shifter[DATA_WIDTH-1].
  - Each edge shifts by one and increments bit_cnt.
  - On the edge where bit_cnt==DATA_WIDTH-1, go to GAP with gap_cnt=0.
  - Exactly DATA_WIDTH consecutive out_valid cycles per word, never interrupted.
- GAP:
  - out_valid=0 and serial_out=0 for exactly GAP_CYCLES cycles.
  - On the final gap edge: if hold_full, load and go straight to SHIFT (no IDLE cycle); otherwise go to IDLE.
  - Back-to-back period is therefore DATA_WIDTH+GAP_CYCLES cycles (9 at defaults).
- Simultaneous accept and load on the same edge (hold_full=1, in_ready=0): no accept occurs that cycle. in_ready rises on the following cycle.
- Counter widths: bit_cnt is $clog2(DATA_WIDTH) bits; gap_cnt is 4 bits. There is no wrap beyond the terminal counts.
- Outputs are driven only from registers. No latches and no X on outputs after reset.
- Assertions:
  - out_valid is never high in IDLE or GAP.
  - Every out_valid run length is DATA_WIDTH.
  - Every gap between runs is at least GAP_CYCLES.

Decomposition:
- Shared package serdes_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - SERDES_WIDTH=8;
  - SERDES_MIN_GAP=1 (the shared width/gap contract between this block and the SIPO).
- One natural sub-module, piso_hold_reg: the single-entry valid/ready holding register (push, pop, full).
- The FSM and shifter stay in the top level.

Test Plan:
- Reset, then single word 0xA5 -> out_valid high for 8 cycles; serial_out sequence 1,0,1,0,0,1,0,1; then out_valid=0; busy=0 after the gap; in_ready=1 throughout once the word is loaded.
- Back-to-back words 0x3C, 0xF0 with in_valid held high -> bit runs of 8, separated by exactly 1 idle cycle; second run 0,0,0,0,1,1,1,1; 17 cycles from first bit to last bit.
- Third word offered while holding is full -> in_ready=0, the word is not accepted until the holding register is loaded, no data is lost, and the order is preserved.
- Reset asserted after bit 3 of 0xFF -> out_valid and serial_out go to 0 asynchronously. After release, word 0x01 transmits cleanly as 1,0,0,0,0,0,0,0.
- Loopback into the SIPO model with 0x00, 0xFF, 0x5A, 0x81 -> SIPO data_out reproduces each value in order, one word per 9 cycles.
- LSB_FIRST=0, GAP_CYCLES=3, word 0x80 -> first bit 1 then seven 0s, followed by exactly 3 idle cycles.

Source files
------------

// File: rtl/serdes_pkg.sv
// Width/gap contract shared by the PISO serializer and the downstream SIPO,
// plus the serializer's state encoding.
package serdes_pkg;

  localparam int unsigned SERDES_WIDTH   = 8;
  localparam int unsigned SERDES_MIN_GAP = 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } serdes_state_e;

endpackage

// File: rtl/piso_hold_reg.sv
// Single-entry holding register with a valid/ready style push and a pop from the shifter side.
module piso_hold_reg
  import serdes_pkg::*;
#(
  parameter int unsigned Width = SERDES_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;

  // A push is only honoured while empty, so it never collides with a pop.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: one holding register, a shifter, and an IDLE/SHIFT/GAP FSM
// that emits DATA_WIDTH-bit runs separated by GAP_CYCLES idle cycles.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SERDES_WIDTH,
  parameter int unsigned GAP_CYCLES = SERDES_MIN_GAP,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  serial_out_o,
  output logic                  out_valid_o,
  output logic                  busy_o
);

  localparam int unsigned     CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);
  localparam logic [3:0]      LastGap = 4'(GAP_CYCLES - 1);

  serdes_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  load;

  piso_hold_reg #(
    .Width (DATA_WIDTH)
  ) u_hold (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (in_valid_i),
    .data_i (data_in_i),
    .pop_i  (load),
    .full_o (hold_full),
    .data_o (hold_data)
  );

  // Loading from the final gap cycle skips IDLE so back-to-back words keep the minimum period.
  assign load = hold_full &&
                ((state_q == StIdle) || ((state_q == StGap) && (gap_cnt_q == LastGap)));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: ;
      StShift: begin
        shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LastBit) begin
          state_d   = StGap;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == LastGap) begin
          gap_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d   = StShift;
      shift_d   = hold_data;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign out_valid_o  = (state_q == StShift);
  assign serial_out_o = out_valid_o && (LSB_FIRST ? shift_q[0] : shift_q[DATA_WIDTH-1]);
  assign in_ready_o   = !hold_full;
  assign busy_o       = (state_q != StIdle) || hold_full;

  a_valid_only_in_shift: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> (state_q == StShift));

  // Entry always starts at bit 0, so these pin every run to DATA_WIDTH and every gap to GAP_CYCLES.
  a_run_holds: assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q == StShift) && (bit_cnt_q != LastBit)) |=> (state_q == StShift));

  a_run_ends: assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q == StShift) && (bit_cnt_q == LastBit)) |=> (state_q == StGap));

  a_gap_holds: assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q == StGap) && (gap_cnt_q != LastGap)) |=> (state_q == StGap));

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboarded bench: a default instance (LSB first, 1-cycle gap) and an MSB-first 3-gap instance.
module tb_piso_serializer;

  typedef struct {
    int unsigned dut;
    logic [7:0]  word;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din0, din1;
  logic       vin0, vin1;
  logic       ir0, so0, ov0, bz0;
  logic       ir1, so1, ov1, bz1;
  logic [1:0] ir_v, so_v, ov_v, bz_v;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  exp_t        exp_q[$];
  int unsigned start_q[$];
  int unsigned end_q[$];

  int unsigned run_len  [2];
  logic [7:0]  cur_word [2];
  int unsigned idle     [2];
  int unsigned last_gap [2];
  bit          seen_run [2];
  bit          idle_bad [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ir_v = {ir1, ir0};
  assign so_v = {so1, so0};
  assign ov_v = {ov1, ov0};
  assign bz_v = {bz1, bz0};

  piso_serializer dut0 (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_in_i    (din0),
    .in_valid_i   (vin0),
    .in_ready_o   (ir0),
    .serial_out_o (so0),
    .out_valid_o  (ov0),
    .busy_o       (bz0)
  );

  piso_serializer #(
    .DATA_WIDTH (8),
    .GAP_CYCLES (3),
    .LSB_FIRST  (1'b0)
  ) dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_in_i    (din1),
    .in_valid_i   (vin1),
    .in_ready_o   (ir1),
    .serial_out_o (so1),
    .out_valid_o  (ov1),
    .busy_o       (bz1)
  );

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: rebuilds each word from its bit run (a SIPO model) and pops the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int unsigned gap_req;
      int unsigned pos;
      exp_t        e;
      gap_req = (d == 0) ? 1 : 3;
      if (rst) begin
        run_len[d]  = 0;
        seen_run[d] = 0;
        idle[d]     = 0;
        idle_bad[d] = 0;
      end else if (ov_v[d]) begin
        if (run_len[d] == 0) begin
          if (seen_run[d]) begin
            check(idle[d] >= gap_req, "gap_min", idle[d], gap_req);
            check(!idle_bad[d], "serial_zero_when_idle", idle_bad[d], 0);
            last_gap[d] = idle[d];
          end
          if (d == 0) start_q.push_back(cyc);
          cur_word[d] = 8'h00;
        end
        pos = (d == 0) ? run_len[d] : 7 - run_len[d];
        if (run_len[d] < 8) cur_word[d][pos] = so_v[d];
        run_len[d]++;
      end else begin
        if (run_len[d] != 0) begin
          check(run_len[d] == 8, "run_length", run_len[d], 8);
          if (exp_q.size() == 0) begin
            check(0, "unexpected_word", cur_word[d], -1);
          end else begin
            e = exp_q.pop_front();
            check(e.dut == d && e.word == cur_word[d], (d == 0) ? "word_dut0" : "word_dut1",
                  cur_word[d], e.word);
          end
          if (d == 0) end_q.push_back(cyc - 1);
          seen_run[d] = 1;
          idle[d]     = 0;
          idle_bad[d] = 0;
          run_len[d]  = 0;
        end
        idle[d]++;
        if (so_v[d]) idle_bad[d] = 1;
      end
    end
  end

  // Called at a negedge; returns after the accepting edge, at the following negedge.
  task automatic send(input int d, input logic [7:0] w, output int unsigned stalls,
                      output int unsigned acc);
    exp_t e;
    stalls = 0;
    if (d == 0) begin din0 = w; vin0 = 1'b1; end
    else        begin din1 = w; vin1 = 1'b1; end
    while (!ir_v[d] && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (!ir_v[d]) begin
      check(0, "accept_timeout", stalls, 200);
    end else begin
      @(posedge clk);
      e.dut  = d;
      e.word = w;
      exp_q.push_back(e);
      @(negedge clk);
    end
    acc = cyc;
    if (d == 0) vin0 = 1'b0;
    else        vin1 = 1'b0;
  endtask

  task automatic drain();
    int unsigned g = 0;
    while ((exp_q.size() != 0 || bz_v != 2'b00 || ov_v != 2'b00) && g < 400) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 400) check(0, "drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int unsigned st, st3, acc, k, g;
    bit          rdy_ok;
    logic [7:0]  w;

    rst = 1'b1;
    din0 = '0; din1 = '0; vin0 = 1'b0; vin1 = 1'b0;
    #1;
    check(ir0 == 1'b1, "reset_in_ready", ir0, 1);
    check(ov0 == 1'b0, "reset_out_valid", ov0, 0);
    check(so0 == 1'b0, "reset_serial_out", so0, 0);
    check(bz0 == 1'b0, "reset_busy", bz0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check(ir0 && ir1 && !ov0 && !ov1 && !bz0 && !bz1, "idle_after_release",
          {ir0, ir1, ov0, ov1, bz0, bz1}, 6'b110000);
    @(negedge clk);

    // Single word 0xA5
    send(0, 8'hA5, st, acc);
    rdy_ok = 1'b1;
    g = 0;
    do begin
      @(negedge clk); #1; rdy_ok &= ir0; g++;
    end while (!ov0 && g < 50);
    while (ov0 && g < 50) begin
      @(negedge clk); #1; rdy_ok &= ir0; g++;
    end
    check(g < 50, "a5_run_timeout", g, 50);
    check(bz0 && !so0, "busy_during_gap", {bz0, so0}, 2'b10);
    @(negedge clk); #1;
    check(!bz0, "busy_after_gap", bz0, 0);
    check(rdy_ok, "ready_while_shifting", rdy_ok, 1);
    check(start_q.size() > 0 && start_q[$] == acc + 1, "first_bit_latency",
          (start_q.size() > 0) ? int'(start_q[$] - acc) : -1, 1);
    @(negedge clk);

    // Back-to-back 0x3C, 0xF0, then 0x11 offered while the holding register is full
    k = start_q.size();
    send(0, 8'h3C, st, acc);
    send(0, 8'hF0, st, acc);
    send(0, 8'h11, st3, acc);
    drain();
    check(st3 > 0, "third_word_stalled", st3, 1);
    if (start_q.size() >= k + 2 && end_q.size() >= k + 2) begin
      check(end_q[k+1] - start_q[k] == 16, "b2b_span", end_q[k+1] - start_q[k], 16);
      check(start_q[k+1] - end_q[k] == 2, "b2b_one_idle", start_q[k+1] - end_q[k], 2);
    end else begin
      check(0, "b2b_runs_seen", start_q.size() - k, 2);
    end

    // Reset mid-word aborts 0xFF; 0x01 then goes through cleanly
    send(0, 8'hFF, st, acc);
    g = 0;
    while (run_len[0] < 4 && g < 50) begin
      @(negedge clk); #1; g++;
    end
    check(g < 50, "ff_run_timeout", g, 50);
    rst = 1'b1;
    #1;
    check(!ov0 && !so0, "reset_aborts_outputs", {ov0, so0}, 0);
    check(ir0 && !bz0, "reset_clears_state", {ir0, bz0}, 2'b10);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    send(0, 8'h01, st, acc);
    drain();

    // Loopback stream: one word per 9 cycles
    k = start_q.size();
    send(0, 8'h00, st, acc);
    send(0, 8'hFF, st, acc);
    send(0, 8'h5A, st, acc);
    send(0, 8'h81, st, acc);
    drain();
    for (int i = 1; i < 4; i++) begin
      if (start_q.size() > k + i)
        check(start_q[k+i] - start_q[k+i-1] == 9, "stream_period",
              start_q[k+i] - start_q[k+i-1], 9);
      else
        check(0, "stream_runs_seen", start_q.size() - k, 4);
    end

    // Randomized traffic with random idle spacing
    for (int i = 0; i < 24; i++) begin
      w = 8'($urandom);
      send(0, w, st, acc);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    drain();

    // MSB-first instance with a 3-cycle gap
    send(1, 8'h80, st, acc);
    send(1, 8'($urandom), st, acc);
    drain();
    check(last_gap[1] == 3, "gap3_exact", last_gap[1], 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
